// File: rtl/rps_pkg.sv
// Shared codes and judging rule for the stone/paper/scissors game blocks.
package rps_pkg;

   localparam logic [1:0] MV_STONE    = 2'b00;
   localparam logic [1:0] MV_PAPER    = 2'b01;
   localparam logic [1:0] MV_SCISSORS = 2'b10;
   localparam logic [1:0] MV_INVALID  = 2'b11;

   localparam logic [1:0] RES_TIE     = 2'b00;
   localparam logic [1:0] RES_P1      = 2'b01;
   localparam logic [1:0] RES_P2      = 2'b10;
   localparam logic [1:0] RES_INVALID = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'b00,
      ST_COLLECT    = 2'b01,
      ST_JUDGE      = 2'b10,
      ST_MATCH_OVER = 2'b11
   } state_t;

   function automatic logic [1:0] rps_judge_fn(input logic [1:0] m1, input logic [1:0] m2);
      logic p1_beats;
      p1_beats = (m1 == MV_STONE    && m2 == MV_SCISSORS) ||
                 (m1 == MV_PAPER    && m2 == MV_STONE)    ||
                 (m1 == MV_SCISSORS && m2 == MV_PAPER);
      if (m1 == MV_INVALID || m2 == MV_INVALID) return RES_INVALID;
      else if (m1 == m2)                        return RES_TIE;
      else if (p1_beats)                        return RES_P1;
      else                                      return RES_P2;
   endfunction

endpackage

// File: rtl/rps_judge.sv
// Combinational single-round judge: two move codes in, round result out.
module rps_judge
   import rps_pkg::*;
(
   input  logic [1:0] p1_move,
   input  logic [1:0] p2_move,
   output logic [1:0] result
);

   assign result = rps_judge_fn(p1_move, p2_move);

endmodule

// File: rtl/rps_match_ctrl.sv
// Best-of-N stone/paper/scissors match controller: handshaked move entry,
// per-round judging, score keeping and a forfeit on move timeout.
module rps_match_ctrl
   import rps_pkg::*;
#(
   parameter int WIN_ROUNDS  = 2,
   parameter int SCORE_W     = 2,
   parameter int TIMEOUT_CYC = 255,
   parameter int TO_W        = 8
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [1:0]         p1_move,
   input  logic               p1_valid,
   input  logic [1:0]         p2_move,
   input  logic               p2_valid,
   output logic [1:0]         round_result,
   output logic               round_done,
   output logic               round_to,
   output logic [SCORE_W-1:0] p1_score,
   output logic [SCORE_W-1:0] p2_score,
   output logic               match_done,
   output logic [1:0]         match_winner,
   output logic [1:0]         state_o
);

   generate
      if (WIN_ROUNDS < 1 || (2**SCORE_W) <= WIN_ROUNDS) begin : g_bad_score_w
         $error("rps_match_ctrl: SCORE_W too narrow for WIN_ROUNDS");
      end
      if (TIMEOUT_CYC < 0 || (2**TO_W) <= TIMEOUT_CYC) begin : g_bad_to_w
         $error("rps_match_ctrl: TO_W too narrow for TIMEOUT_CYC");
      end
   endgenerate

   state_t            state, next_state;
   logic              start_q, armed, start_edge;
   logic              p1_lat, p2_lat;
   logic [1:0]        p1_mv, p2_mv;
   logic              forfeit;
   logic [TO_W-1:0]   to_cnt;
   logic [1:0]        winner_q;
   logic [1:0]        judge_res, round_res_c;
   logic              p1_take, p2_take, both_have, timeout_hit;
   logic              p1_win, p2_win;

   rps_judge u_judge (
      .p1_move (p1_mv),
      .p2_move (p2_mv),
      .result  (judge_res)
   );

   // armed is low for the first cycle after reset so a start level held
   // through reset release is not mistaken for a rising edge.
   assign start_edge  = start & ~start_q & armed;
   assign p1_take     = (state == ST_COLLECT) && p1_valid && !p1_lat;
   assign p2_take     = (state == ST_COLLECT) && p2_valid && !p2_lat;
   assign both_have   = (p1_lat || p1_take) && (p2_lat || p2_take);
   assign timeout_hit = (TIMEOUT_CYC != 0) && (state == ST_COLLECT) && (p1_lat ^ p2_lat) &&
                        !both_have && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

   // A forfeit awards the round to whoever moved, unless that move was invalid.
   always_comb begin
      round_res_c = judge_res;
      if (forfeit) begin
         if ((p1_lat ? p1_mv : p2_mv) == MV_INVALID) round_res_c = RES_INVALID;
         else                                        round_res_c = p1_lat ? RES_P1 : RES_P2;
      end
   end

   assign p1_win = (round_res_c == RES_P1);
   assign p2_win = (round_res_c == RES_P2);

   // NOTE: clocked state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   // NOTE: every variable gets a default before the case so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      if (abort) begin
         next_state = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:       if (start_edge) next_state = ST_COLLECT;
            ST_COLLECT:    if (both_have || timeout_hit) next_state = ST_JUDGE;
            ST_JUDGE: begin
               if ((p1_win && p1_score == SCORE_W'(WIN_ROUNDS - 1)) ||
                   (p2_win && p2_score == SCORE_W'(WIN_ROUNDS - 1)))
                  next_state = ST_MATCH_OVER;
               else
                  next_state = ST_COLLECT;
            end
            ST_MATCH_OVER: if (start_edge) next_state = ST_COLLECT;
            default:       next_state = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      state_o      = state;
      match_done   = (state == ST_MATCH_OVER);
      match_winner = match_done ? winner_q : 2'b00;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         start_q      <= 1'b0;
         armed        <= 1'b0;
         p1_lat       <= 1'b0;
         p2_lat       <= 1'b0;
         p1_mv        <= MV_STONE;
         p2_mv        <= MV_STONE;
         forfeit      <= 1'b0;
         to_cnt       <= '0;
         p1_score     <= '0;
         p2_score     <= '0;
         round_result <= RES_TIE;
         round_to     <= 1'b0;
         round_done   <= 1'b0;
         winner_q     <= 2'b00;
      end else begin
         start_q    <= start;
         armed      <= 1'b1;
         round_done <= 1'b0;
         if (abort) begin
            p1_lat       <= 1'b0;
            p2_lat       <= 1'b0;
            p1_mv        <= MV_STONE;
            p2_mv        <= MV_STONE;
            forfeit      <= 1'b0;
            to_cnt       <= '0;
            p1_score     <= '0;
            p2_score     <= '0;
            round_result <= RES_TIE;
            round_to     <= 1'b0;
            winner_q     <= 2'b00;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start_edge) begin
                     p1_score     <= '0;
                     p2_score     <= '0;
                     round_result <= RES_TIE;
                     round_to     <= 1'b0;
                  end
               end
               ST_COLLECT: begin
                  if (p1_take) begin
                     p1_lat <= 1'b1;
                     p1_mv  <= p1_move;
                  end
                  if (p2_take) begin
                     p2_lat <= 1'b1;
                     p2_mv  <= p2_move;
                  end
                  to_cnt <= (p1_lat ^ p2_lat) ? to_cnt + TO_W'(1) : '0;
                  if (timeout_hit) forfeit <= 1'b1;
               end
               ST_JUDGE: begin
                  round_result <= round_res_c;
                  round_to     <= forfeit;
                  round_done   <= 1'b1;
                  if (p1_win) p1_score <= p1_score + SCORE_W'(1);
                  if (p2_win) p2_score <= p2_score + SCORE_W'(1);
                  winner_q     <= p1_win ? RES_P1 : (p2_win ? RES_P2 : 2'b00);
                  p1_lat       <= 1'b0;
                  p2_lat       <= 1'b0;
                  p1_mv        <= MV_STONE;
                  p2_mv        <= MV_STONE;
                  forfeit      <= 1'b0;
                  to_cnt       <= '0;
               end
               ST_MATCH_OVER: begin
                  if (start_edge) begin
                     p1_score <= '0;
                     p2_score <= '0;
                     winner_q <= 2'b00;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
